fill_readout_sequencer: RTL
===========================

Name: fill_readout_sequencer

Overview:
- Sequences DDR3 readout of stored fills in the clk125 (local) domain.
- On each readout request it pops one fill header from the fill-header FIFO (first-word-fall-through) and decodes the start address and burst count.
- It then drives ddr3_rd_start_addr / ddr3_rd_burst_cnt / enable_reading into ddr3_intf, waits for reading_done, and reports completion, status and fill number back to the master-FPGA command logic.

Parameters:
- TIMEOUT_CYCLES, 32'd12500000, max clk125 cycles in WAIT_DONE before abort (100 ms).
- MAX_BURSTS, 24'h800000, largest legal burst count (whole 23-bit address space).

Ports:
- clk125  input  1  local readout clock, all logic on rising edge
- reset_clk125_n  input  1  asynchronous active-low reset
- readout_req  input  1  one-cycle pulse: read out the next stored fill
- fill_header_fifo_empty  input  1  no header available when high
- fill_header_fifo_out  input  128  FWFT head of header FIFO: [22:0] start burst addr, [46:23] burst count, [70:47] fill number, rest ignored
- fill_header_fifo_rd_en  output  1  pop header FIFO
- ddr3_rd_start_addr  output  23  first 128-bit burst address
- ddr3_rd_burst_cnt  output  24  number of bursts to read
- enable_reading  output  1  level; ddr3_intf reads while high
- reading_done  input  1  ddr3_intf finished all bursts
- readout_busy  output  1  high in any state except IDLE
- readout_done  output  1  one-cycle pulse at end of every serviced request
- readout_status  output  2  valid with readout_done: 00 ok, 01 bad count, 10 timeout
- readout_fill_num  output  24  fill number of last popped header
- readout_fill_cnt  output  16  count of fills completed with status 00, wraps

Behaviour:
- Reset (async, while reset_clk125_n low): state IDLE, all outputs 0, pending flag 0, timeout counter 0.
- Pending flag:
  - Set by readout_req.
  - Cleared when the header is popped.
  - A readout_req while pending or busy is dropped; there is no queueing beyond one.
- IDLE:
  - If pending and !fill_header_fifo_empty: capture the addr, count and fill-num fields from fill_header_fifo_out, assert fill_header_fifo_rd_en for exactly this one cycle, go to CHECK.
  - If pending and the FIFO is empty: stay in IDLE with readout_busy low. The pop happens the first cycle the FIFO is non-empty.
- CHECK (1 cycle):
  - If count == 0 or count > MAX_BURSTS: go to FINISH with status 01.
  - Otherwise drive ddr3_rd_start_addr and ddr3_rd_burst_cnt from the captured fields and go to START. Both stay stable until the next header is accepted.
  - Address wrap (start + count beyond 2^23) is legal; ddr3_intf wraps modulo 2^23.
- START (1 cycle): enable_reading goes high; timeout counter cleared; go to WAIT_DONE.
- WAIT_DONE:
  - enable_reading is held high; the counter increments each cycle.
  - On reading_done = 1: go to FINISH with status 00. reading_done has priority over a same-cycle timeout.
  - If the counter reaches TIMEOUT_CYCLES-1 without reading_done: go to FINISH with status 10.
- FINISH (1 cycle):
  - enable_reading low, readout_done = 1, readout_status updated; readout_fill_cnt increments only for status 00.
  - Return to IDLE.
  - readout_status and readout_fill_num hold until the next FINISH.
- Latency:
  - From readout_req (FIFO non-empty) to enable_reading high: 3 cycles (req registered, pop, CHECK).
  - From reading_done to readout_done: 1 cycle.
- reading_done seen outside WAIT_DONE is ignored.
- Reset mid-operation: enable_reading drops immediately (async). The captured header is lost; the FIFO is not re-pushed.

Test Plan:
- Header addr=23'h000100, cnt=24'd16, fill=24'd7; readout_req; reading_done after 20 cycles -> rd_en 1 pulse, enable_reading high 3 cycles after req, addr/cnt = 0x100/16, readout_done 1 cycle after reading_done, status 00, fill_num 7, fill_cnt 1.
- Header cnt=0 -> header popped, enable_reading never asserts, readout_done with status 01, fill_cnt unchanged; same result for cnt = 24'h800001.
- TIMEOUT_CYCLES=100, reading_done never asserted -> enable_reading high exactly 100 cycles, then readout_done with status 10.
- readout_req with FIFO empty, header written 50 cycles later -> pop on the first non-empty cycle; a second readout_req during WAIT_DONE is dropped (only one readout_done).
- reading_done and timeout in the same cycle -> status 00.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously; after release, the next req pops the next header normally; addr=23'h7FFFF0, cnt=32 is accepted with status 00.

Source files
------------

// File: rtl/fill_readout_sequencer_if.sv
// Handshake bundle between the fill readout sequencer, the header FIFO,
// ddr3_intf and the master-FPGA command logic.
interface fill_readout_sequencer_if;
    logic         readout_req;
    logic         fill_header_fifo_empty;
    logic [127:0] fill_header_fifo_out;
    logic         fill_header_fifo_rd_en;
    logic [22:0]  ddr3_rd_start_addr;
    logic [23:0]  ddr3_rd_burst_cnt;
    logic         enable_reading;
    logic         reading_done;
    logic         readout_busy;
    logic         readout_done;
    logic [1:0]   readout_status;
    logic [23:0]  readout_fill_num;
    logic [15:0]  readout_fill_cnt;

    modport master (
        input  readout_req,
        input  fill_header_fifo_empty,
        input  fill_header_fifo_out,
        input  reading_done,
        output fill_header_fifo_rd_en,
        output ddr3_rd_start_addr,
        output ddr3_rd_burst_cnt,
        output enable_reading,
        output readout_busy,
        output readout_done,
        output readout_status,
        output readout_fill_num,
        output readout_fill_cnt
    );

    modport slave (
        output readout_req,
        output fill_header_fifo_empty,
        output fill_header_fifo_out,
        output reading_done,
        input  fill_header_fifo_rd_en,
        input  ddr3_rd_start_addr,
        input  ddr3_rd_burst_cnt,
        input  enable_reading,
        input  readout_busy,
        input  readout_done,
        input  readout_status,
        input  readout_fill_num,
        input  readout_fill_cnt
    );
endinterface

// File: rtl/fill_readout_sequencer.sv
// Pops one fill header per readout request, runs the DDR3 read through
// ddr3_intf and reports status, fill number and good-fill count.
module fill_readout_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd12500000,
    parameter logic [23:0] MAX_BURSTS     = 24'h800000
) (
    input  logic                        clk125,
    input  logic                        reset_clk125_n,
    fill_readout_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [1:0]   fin_status_s;
    logic         pop_s;
    logic         bad_cnt_s;
    logic         tmo_hit_s;

    logic         pending_r;
    logic [22:0]  hdr_addr_r;
    logic [23:0]  hdr_cnt_r;
    logic [23:0]  hdr_fill_r;
    logic [31:0]  tmo_cnt_r;
    logic [22:0]  rd_addr_r;
    logic [23:0]  rd_cnt_r;
    logic         enable_r;
    logic         busy_r;
    logic         done_r;
    logic [1:0]   status_r;
    logic [23:0]  fill_num_r;
    logic [15:0]  fill_cnt_r;

    // The pop stays combinational so the FWFT head is taken in the first cycle it is valid.
    assign pop_s     = (state_r == IDLE) && pending_r && !bus.fill_header_fifo_empty;
    assign bad_cnt_s = (hdr_cnt_r == 24'd0) || (hdr_cnt_r > MAX_BURSTS);
    assign tmo_hit_s = ((tmo_cnt_r + 32'd1) == (TIMEOUT_CYCLES - 32'd1));

    // Next-state and completion-status decode
    always_comb begin
        state_next_s = state_r;
        fin_status_s = 2'b00;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CHECK: begin
                if (bad_cnt_s) begin
                    state_next_s = FINISH;
                    fin_status_s = 2'b01;
                end else begin
                    state_next_s = START;
                end
            end
            START: begin
                state_next_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.reading_done) begin
                    state_next_s = FINISH;
                    fin_status_s = 2'b00;
                end else if (tmo_hit_s) begin
                    state_next_s = FINISH;
                    fin_status_s = 2'b10;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            FINISH: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // One-deep request latch; requests while pending or busy are dropped
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            pending_r <= 1'b0;
        end else if (pop_s) begin
            pending_r <= 1'b0;
        end else if (bus.readout_req && (state_r == IDLE)) begin
            pending_r <= 1'b1;
        end
    end

    // Header field capture on pop
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            hdr_addr_r <= 23'd0;
            hdr_cnt_r  <= 24'd0;
            hdr_fill_r <= 24'd0;
        end else if (pop_s) begin
            hdr_addr_r <= bus.fill_header_fifo_out[22:0];
            hdr_cnt_r  <= bus.fill_header_fifo_out[46:23];
            hdr_fill_r <= bus.fill_header_fifo_out[70:47];
        end
    end

    // Read window timeout counter
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r == START) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r == WAIT_DONE) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end

    // DDR3 read command, only updated by a header that passed the count check
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            rd_addr_r <= 23'd0;
            rd_cnt_r  <= 24'd0;
        end else if ((state_r == CHECK) && !bad_cnt_s) begin
            rd_addr_r <= hdr_addr_r;
            rd_cnt_r  <= hdr_cnt_r;
        end
    end

    // Registered state-derived strobes
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            enable_r <= (state_next_s == START) || (state_next_s == WAIT_DONE);
            busy_r   <= (state_next_s != IDLE);
            done_r   <= (state_next_s == FINISH);
        end
    end

    // Completion report, held until the next finish
    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            status_r   <= 2'b00;
            fill_num_r <= 24'd0;
            fill_cnt_r <= 16'd0;
        end else if (state_next_s == FINISH) begin
            status_r   <= fin_status_s;
            fill_num_r <= hdr_fill_r;
            if (fin_status_s == 2'b00) begin
                fill_cnt_r <= fill_cnt_r + 16'd1;
            end
        end
    end

    assign bus.fill_header_fifo_rd_en = pop_s;
    assign bus.ddr3_rd_start_addr     = rd_addr_r;
    assign bus.ddr3_rd_burst_cnt      = rd_cnt_r;
    assign bus.enable_reading         = enable_r;
    assign bus.readout_busy           = busy_r;
    assign bus.readout_done           = done_r;
    assign bus.readout_status         = status_r;
    assign bus.readout_fill_num       = fill_num_r;
    assign bus.readout_fill_cnt       = fill_cnt_r;

endmodule
